// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: after init, grants refresh, write or read bursts
// to the shared SDRAM pins. Refresh has priority; write and read alternate on a tie.
module sdram_arbit (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    output logic        aref_en,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    output logic        wr_en,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    inout  wire  [15:0] sdram_dq
);

    localparam logic [2:0] INIT  = 3'd0;
    localparam logic [2:0] ARBIT = 3'd1;
    localparam logic [2:0] AREF  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] READ  = 3'd4;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [1:0]  BA_IDLE  = 2'b11;
    localparam logic [12:0] ADDR_IDLE = 13'h1FFF;

    logic [2:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;  // 0 = write granted last, 1 = read
    logic [3:0] cmd;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            INIT: begin
                if (init_end) state_d = ARBIT;
            end
            ARBIT: begin
                if (aref_req) begin
                    state_d = AREF;
                end else if (wr_req && (!rd_req || last_grant_q)) begin
                    state_d      = WRITE;
                    last_grant_d = 1'b0;
                end else if (rd_req) begin
                    state_d      = READ;
                    last_grant_d = 1'b1;
                end
            end
            AREF: begin
                if (aref_end) state_d = ARBIT;
            end
            WRITE: begin
                if (wr_end) state_d = ARBIT;
            end
            READ: begin
                if (rd_end) state_d = ARBIT;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= INIT;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Pins follow the owning source with no register in the path.
    always_comb begin
        cmd        = CMD_NOP;
        sdram_ba   = BA_IDLE;
        sdram_addr = ADDR_IDLE;
        case (state_q)
            INIT: begin
                cmd        = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                cmd        = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd        = CMD_NOP;
                sdram_ba   = BA_IDLE;
                sdram_addr = ADDR_IDLE;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke = 1'b1;

    assign aref_en = (state_q == AREF);
    assign wr_en   = (state_q == WRITE);
    assign rd_en   = (state_q == READ);

    assign sdram_dq = (wr_en && wr_sdram_en) ? wr_sdram_data : 16'hzzzz;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: stimulus pushes the hand-derived expected
// state per cycle; a negedge monitor pops and checks grants, pins and dq.
module tb_sdram_arbit;

    localparam int S_INIT = 0, S_ARBIT = 1, S_AREF = 2, S_WRITE = 3, S_READ = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b0010;
    logic [1:0]  init_ba = 2'd0;
    logic [12:0] init_addr = 13'h0400;
    logic        aref_req = 1'b0, aref_end = 1'b0;
    logic [3:0]  aref_cmd = 4'b0001;
    logic [1:0]  aref_ba = 2'd1;
    logic [12:0] aref_addr = 13'h0AAA;
    logic        aref_en;
    logic        wr_req = 1'b0, wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0100;
    logic [1:0]  wr_ba = 2'd2;
    logic [12:0] wr_addr = 13'h0123;
    logic        wr_sdram_en = 1'b0;
    logic [15:0] wr_sdram_data = 16'hA5A5;
    logic        wr_en;
    logic        rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0101;
    logic [1:0]  rd_ba = 2'd3;
    logic [12:0] rd_addr = 13'h0456;
    logic        rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    wire  [15:0] sdram_dq;

    always #5 sys_clk = ~sys_clk;

    sdram_arbit dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr), .aref_en(aref_en),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data), .wr_en(wr_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
    );

    typedef struct {
        int    st;
        bit    drv;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Stimulus: inputs for this cycle are already set; record what must be seen.
    task automatic chk(input int st, input bit drv, input string tag);
        exp_t e;
        e.st  = st;
        e.drv = drv;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [2:0]  g_exp, g_act;
            logic [19:0] p_exp, p_act;
            e = exp_q.pop_front();
            g_exp = {e.st == S_AREF, e.st == S_WRITE, e.st == S_READ};
            g_act = {aref_en, wr_en, rd_en};
            case (e.st)
                S_INIT:  p_exp = {1'b1, init_cmd, init_ba, init_addr};
                S_AREF:  p_exp = {1'b1, aref_cmd, aref_ba, aref_addr};
                S_WRITE: p_exp = {1'b1, wr_cmd, wr_ba, wr_addr};
                S_READ:  p_exp = {1'b1, rd_cmd, rd_ba, rd_addr};
                default: p_exp = {1'b1, 4'b0111, 2'b11, 13'h1FFF};
            endcase
            p_act = {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                     sdram_ba, sdram_addr};
            n_cmp++;
            if (g_act !== g_exp) begin
                n_bad++;
                $display("FAIL %s grants {aref,wr,rd}: got %b want %b", e.tag, g_act, g_exp);
            end
            n_cmp++;
            if (p_act !== p_exp) begin
                n_bad++;
                $display("FAIL %s pins {cke,cmd,ba,addr}: got %h want %h", e.tag, p_act, p_exp);
            end
            n_cmp++;
            if (e.drv ? (sdram_dq !== wr_sdram_data) : (sdram_dq === wr_sdram_data)) begin
                n_bad++;
                $display("FAIL %s dq: got %h want %s", e.tag, sdram_dq,
                         e.drv ? "A5A5 driven" : "released");
            end
        end
    end

    initial begin
        @(posedge sys_clk);
        #1;
        chk(S_INIT, 0, "rst0");
        chk(S_INIT, 0, "rst1");
        sys_rst = 1'b0;
        chk(S_INIT, 0, "init_wait0");
        chk(S_INIT, 0, "init_wait1");
        init_end = 1'b1;
        chk(S_INIT, 0, "init_end_cyc");
        init_end = 1'b0;
        chk(S_ARBIT, 0, "arbit_nop");
        chk(S_ARBIT, 0, "arbit_idle");
        // Tie: first grant goes to write
        wr_req = 1'b1; rd_req = 1'b1; wr_sdram_en = 1'b1;
        chk(S_ARBIT, 0, "tie_decide");
        chk(S_WRITE, 1, "wr_dq_drive");
        wr_sdram_en = 1'b0;
        chk(S_WRITE, 0, "wr_dq_release");
        wr_end = 1'b1;
        chk(S_WRITE, 0, "wr_end_cyc");
        wr_end = 1'b0; wr_sdram_en = 1'b1;
        chk(S_ARBIT, 0, "tie2_decide");
        chk(S_READ, 0, "rd_after_wr");
        rd_end = 1'b1;
        chk(S_READ, 0, "rd_end_cyc");
        rd_end = 1'b0;
        chk(S_ARBIT, 0, "tie3_decide");
        wr_req = 1'b0; rd_req = 1'b0;
        chk(S_WRITE, 1, "wr_after_rd");
        // Refresh request during a write must not preempt it
        aref_req = 1'b1;
        chk(S_WRITE, 1, "aref_no_preempt0");
        chk(S_WRITE, 1, "aref_no_preempt1");
        wr_end = 1'b1;
        chk(S_WRITE, 1, "wr_end_aref_wait");
        wr_end = 1'b0;
        chk(S_ARBIT, 0, "aref_decide");
        aref_req = 1'b0; wr_end = 1'b1;
        chk(S_AREF, 0, "aref_stale_wr_end");
        wr_end = 1'b0; aref_end = 1'b1;
        chk(S_AREF, 0, "aref_end_cyc");
        aref_end = 1'b0;
        // All three request together, plus a stale rd_end: refresh wins
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1; rd_end = 1'b1;
        chk(S_ARBIT, 0, "all3_decide");
        aref_req = 1'b0; rd_end = 1'b0;
        chk(S_AREF, 0, "all3_aref");
        aref_end = 1'b1;
        chk(S_AREF, 0, "all3_aref_end");
        aref_end = 1'b0;
        chk(S_ARBIT, 0, "tie4_decide");
        wr_req = 1'b0;
        chk(S_READ, 0, "rd_tie_after_wr");
        rd_end = 1'b1;
        chk(S_READ, 0, "rd_end2");
        rd_end = 1'b0;
        chk(S_ARBIT, 0, "single_rd_decide");
        chk(S_READ, 0, "single_rd_grant");
        // Asynchronous reset mid-read, applied between clock edges
        sys_rst = 1'b1;
        chk(S_INIT, 0, "rst_mid_read");
        chk(S_INIT, 0, "rst_hold");
        sys_rst = 1'b0; wr_req = 1'b1;
        chk(S_INIT, 0, "post_rst_wait0");
        chk(S_INIT, 0, "post_rst_wait1");
        init_end = 1'b1;
        chk(S_INIT, 0, "post_rst_init_end");
        init_end = 1'b0;
        chk(S_ARBIT, 0, "post_rst_decide");
        wr_req = 1'b0; rd_req = 1'b0;
        chk(S_WRITE, 1, "post_rst_tie_write");
        wr_end = 1'b1;
        chk(S_WRITE, 1, "post_rst_wr_end");
        wr_end = 1'b0;
        chk(S_ARBIT, 0, "final_idle");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge sys_clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
